// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, immediate-type selects and the
// decoded instruction entry held by the ID stage.
package rv_pkg;

  localparam int XLEN = 32;

  // Major opcodes (instr[6:0]) recognised by RV32I.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate-type select, consumed by the immediate generator.
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  // One buffered instruction with its pre-decoded attributes.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      imm_sel;
    logic            illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{pc: '0, instr: '0, imm_sel: IMM_NONE, illegal: 1'b0};

endpackage

// File: rtl/id_predecode.sv
// Opcode pre-decode: maps a raw instruction to its immediate-type select
// and flags anything that is not an RV32I encoding.
module id_predecode
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  imm_sel,
  output logic        illegal
);

  // Classify the opcode; compressed/reserved low bits are always illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      unique case (instr[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: imm_sel = IMM_I;
        OPC_STORE:           imm_sel = IMM_S;
        OPC_BRANCH:          imm_sel = IMM_B;
        OPC_LUI, OPC_AUIPC:  imm_sel = IMM_U;
        OPC_JAL:             imm_sel = IMM_J;
        OPC_OP:              imm_sel = IMM_NONE;
        default:             illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_stage.sv
// IF/ID pipeline stage: two-entry skid buffer (head + skid) holding
// pre-decoded instructions. All outputs come from the head register and
// in_ready is itself a register, so no combinational path crosses the stage.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [24:0]     out_imm_field,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state, state_nxt;
  entry_t head, skid, in_entry;
  logic   in_fire, out_fire;
  logic [2:0] in_imm_sel;
  logic       in_illegal;

  id_predecode u_predecode (
    .instr   (in_instr),
    .imm_sel (in_imm_sel),
    .illegal (in_illegal)
  );

  assign in_entry = '{pc: in_pc, instr: in_instr, imm_sel: in_imm_sel, illegal: in_illegal};
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next occupancy from the transfers seen this cycle; flush wins over both.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (in_fire) state_nxt = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_nxt = TWO;
          else if (!in_fire && out_fire) state_nxt = EMPTY;
        end
        TWO:     if (out_fire) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so it never depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= (state_nxt != TWO);
  end

  // Head/skid data movement; contents are don't-care once flushed.
  always_ff @(posedge clk) begin
    // NOTE: the two entry registers are reset so the idle outputs are a defined, harmless decode.
    if (rst) begin
      head <= ENTRY_RST;
      skid <= ENTRY_RST;
    end else if (!flush) begin
      unique case (state)
        EMPTY: if (in_fire) head <= in_entry;
        ONE: begin
          if (in_fire && out_fire) head <= in_entry;
          else if (in_fire)        skid <= in_entry;
        end
        TWO:     if (out_fire) head <= skid;
        default: ;
      endcase
    end
  end

  // Output decode: valid from occupancy, fields sliced from the head entry.
  always_comb begin
    out_valid     = (state != EMPTY);
    out_pc        = head.pc;
    out_instr     = head.instr;
    out_rd        = head.instr[11:7];
    out_rs1       = head.instr[19:15];
    out_rs2       = head.instr[24:20];
    out_funct3    = head.instr[14:12];
    out_funct7    = head.instr[31:25];
    out_imm_field = head.instr[31:7];
    out_imm_sel   = head.imm_sel;
    out_illegal   = head.illegal;
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode table streamed without stalls,
// then hand-written backpressure, flush and reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_instr;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_imm_sel;
  logic [6:0]  out_funct7;
  logic [24:0] out_imm_field;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm_field(out_imm_field), .out_imm_sel(out_imm_sel), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic check_head(input string name, input logic [31:0] instr, input logic [31:0] pc);
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check({name, " instr"}, out_instr, instr);
    check({name, " pc"}, out_pc, pc);
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 3'b000, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h0020A423, 3'b001, 1'b0}; // sw
    vecs[2]  = '{32'h00000063, 3'b010, 1'b0}; // beq
    vecs[3]  = '{32'h123452B7, 3'b011, 1'b0}; // lui x5
    vecs[4]  = '{32'h0000006F, 3'b100, 1'b0}; // jal
    vecs[5]  = '{32'h00000033, 3'b111, 1'b0}; // add
    vecs[6]  = '{32'h0000A103, 3'b000, 1'b0}; // lw
    vecs[7]  = '{32'h00000017, 3'b011, 1'b0}; // auipc
    vecs[8]  = '{32'h000080E7, 3'b000, 1'b0}; // jalr
    vecs[9]  = '{32'h0000000F, 3'b000, 1'b0}; // fence
    vecs[10] = '{32'h00000073, 3'b000, 1'b0}; // ecall
    vecs[11] = '{32'h00000000, 3'b111, 1'b1}; // all zero
    vecs[12] = '{32'h0000007F, 3'b111, 1'b1}; // reserved opcode
    vecs[13] = '{32'h00000053, 3'b111, 1'b1}; // OP-FP, not RV32I
    vecs[14] = '{32'h00000092, 3'b111, 1'b1}; // low bits 10

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst imm_sel", 32'(out_imm_sel), 32'd7);
    check("rst illegal", 32'(out_illegal), 32'd0);
    check("rst instr", out_instr, 32'd0);
    rst = 1'b0;
    tick();
    check("post-rst in_ready", 32'(in_ready), 32'd1);
    check("post-rst out_valid", 32'(out_valid), 32'd0);

    // Stream the table with no stalls: each instruction becomes head one cycle later.
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      logic [31:0] w;
      w = vecs[i].instr;
      send(w, 32'(i * 4));
      tick();
      check_head($sformatf("vec%0d", i), w, 32'(i * 4));
      check($sformatf("vec%0d imm_sel", i), 32'(out_imm_sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
      check($sformatf("vec%0d rd", i), 32'(out_rd), 32'(w[11:7]));
      check($sformatf("vec%0d rs1", i), 32'(out_rs1), 32'(w[19:15]));
      check($sformatf("vec%0d rs2", i), 32'(out_rs2), 32'(w[24:20]));
      check($sformatf("vec%0d funct3", i), 32'(out_funct3), 32'(w[14:12]));
      check($sformatf("vec%0d funct7", i), 32'(out_funct7), 32'(w[31:25]));
      check($sformatf("vec%0d imm_field", i), 32'(out_imm_field), 32'(w[31:7]));
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      if (i == 0) begin
        check("addi rd", 32'(out_rd), 32'd1);
        check("addi imm_field", 32'(out_imm_field), 32'h00A001);
      end
      if (i == 3) check("lui rd", 32'(out_rd), 32'd5);
    end
    in_valid = 1'b0;
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Backpressure: third instruction must wait until the buffer drains.
    out_ready = 1'b0;
    send(32'h00100113, 32'h100);
    tick();
    check_head("bp A", 32'h00100113, 32'h100);
    check("bp in_ready one", 32'(in_ready), 32'd1);
    send(32'h00200193, 32'h104);
    tick();
    check("bp in_ready two", 32'(in_ready), 32'd0);
    check_head("bp A hold1", 32'h00100113, 32'h100);
    send(32'h00300213, 32'h108);
    tick();
    check_head("bp A hold2", 32'h00100113, 32'h100);
    check("bp rd hold", 32'(out_rd), 32'd2);
    check("bp in_ready stall", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check_head("bp B", 32'h00200193, 32'h104);
    check("bp in_ready reopen", 32'(in_ready), 32'd1);
    tick();
    check_head("bp C", 32'h00300213, 32'h108);
    in_valid = 1'b0;
    tick();
    check("bp drained", 32'(out_valid), 32'd0);

    // Flush in TWO with simultaneous in_valid and out_ready.
    out_ready = 1'b0;
    send(32'h00400293, 32'h200); tick();
    send(32'h00500313, 32'h204); tick();
    check("fl two in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    send(32'h00600393, 32'h208);
    tick();
    check("fl out_valid", 32'(out_valid), 32'd0);
    check("fl in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl stays empty", 32'(out_valid), 32'd0);

    // Flush in ONE drops the head and an accepted-looking incoming instruction.
    out_ready = 1'b0;
    send(32'h00700413, 32'h300); tick();
    flush = 1'b1;
    send(32'h00800493, 32'h304);
    tick();
    check("fl1 out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    send(32'h00900513, 32'h308);
    tick();
    check_head("fl1 next", 32'h00900513, 32'h308);
    in_valid = 1'b0;
    tick();
    check("fl1 drained", 32'(out_valid), 32'd0);

    // Reset while TWO entries are buffered.
    out_ready = 1'b0;
    send(32'h00A00593, 32'h400); tick();
    send(32'h00B00613, 32'h404); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst out_valid", 32'(out_valid), 32'd0);
    check("mrst in_ready", 32'(in_ready), 32'd0);
    check("mrst imm_sel", 32'(out_imm_sel), 32'd7);
    check("mrst instr", out_instr, 32'd0);
    rst = 1'b0;
    tick();
    check("mrst after out_valid", 32'(out_valid), 32'd0);
    check("mrst after in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(32'h00C00693, 32'h500);
    tick();
    check_head("mrst first", 32'h00C00693, 32'h500);
    check("mrst first imm_sel", 32'(out_imm_sel), 32'd0);
    in_valid = 1'b0;
    tick();
    check("mrst drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
